ex_muldiv_ctrl: RTL
===================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width (matches datapath word).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ex_valid  input  1  EX pipeline register holds a valid instruction.
REQ-005 md_req  input  1  EX instruction is a multiply/divide op.
REQ-006 md_op  input  2  00 MULU, 01 DIVU, 10/11 reserved.
REQ-007 opa  input  WIDTH  operand A (multiplicand/dividend), from read_data_1 path.
REQ-008 opb  input  WIDTH  operand B (multiplier/divisor), from read_data_2 path.
REQ-009 flush  input  1  kill EX instruction (branch taken).
REQ-010 stall  output  1  hold IF/ID/EX pipeline registers.
REQ-011 res_valid  output  1  one-cycle pulse; res_lo/res_hi valid.
REQ-012 res_lo  output  WIDTH  product low half / quotient.
REQ-013 res_hi  output  WIDTH  product high half / remainder.
REQ-014 div_zero  output  1  pulses with res_valid when DIVU divisor is 0.
REQ-015 illegal  output  1  pulses with res_valid for reserved md_op.

Function
REQ-016 FSM states IDLE, BUSY, DONE; encoding free.
REQ-017 IDLE->BUSY when ex_valid & md_req & ~flush & legal op; opa/opb/md_op latched on that edge; step counter cleared.
REQ-018 BUSY: one radix-2 step per cycle (shift-add MULU, restoring DIVU); counter increments; BUSY->DONE after exactly WIDTH steps.
REQ-019 DONE: res_valid=1 for one cycle, results held until next acceptance; DONE->IDLE unconditionally; md_req sampled in DONE is ignored (it is the retiring instruction).
REQ-020 Latency: acceptance edge at cycle 0 -> res_valid high in cycle WIDTH+1.
REQ-021 stall = (IDLE & ex_valid & md_req & ~flush) | BUSY; stall low in DONE so the result advances with its instruction.
REQ-022 DIVU with opb==0: IDLE->DONE directly (no BUSY), res_lo={WIDTH{1}}, res_hi=opa, div_zero=1.
REQ-023 Reserved md_op: IDLE->DONE directly, res_lo=res_hi=0, illegal=1.
REQ-024 flush in BUSY: ->IDLE next edge, no res_valid, stall low in the flush cycle; flush in IDLE blocks acceptance.
REQ-025 Product is full 2*WIDTH unsigned; no overflow possible; all arithmetic unsigned.

Reset
REQ-026 rst has priority over all inputs, including mid-BUSY: state=IDLE, counter=0, stall=0, res_valid=0, div_zero=0, illegal=0, res_lo=res_hi=0.
REQ-027 Operand/accumulator registers reset to 0.

Configuration
REQ-028 Macro MULDIV_DIV_EN: defined -> DIVU supported per REQ-018/022.
REQ-029 MULDIV_DIV_EN undefined -> md_op 01 treated as reserved (REQ-023), no divider logic synthesized, div_zero tied 0.

Structure
REQ-030 Shared package holds md_op encodings (MD_MULU, MD_DIVU), FSM state typedef and default WIDTH constant.
REQ-031 One sub-module, muldiv_iter: step datapath (accumulator, shift register, step enable, mode); ex_muldiv_ctrl owns FSM, counter, handshakes.

Verification
REQ-032 MULU opa=0x0012 opb=0x0034 -> res_valid in cycle 17, res_hi=0x0000 res_lo=0x03A8, stall high cycles 0-16, low in 17.
REQ-033 MULU 0xFFFF*0xFFFF -> res_hi=0xFFFE res_lo=0x0001.
REQ-034 DIVU 100/7 (MULDIV_DIV_EN) -> res_lo=0x000E res_hi=0x0002; DIVU 0x1234/0 -> next cycle res_valid, div_zero=1, res_lo=0xFFFF, res_hi=0x1234, no BUSY.
REQ-035 MULU accepted, flush at step 5 -> IDLE next edge, no res_valid, stall low; new MULU accepted in following cycle completes correctly.
REQ-036 rst asserted at step 8 of DIVU -> all outputs zero next edge; md_op=10 -> illegal pulse, results 0; without MULDIV_DIV_EN md_op=01 -> illegal pulse.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared encodings and FSM state type for the EX-stage multiply/divide unit.
// Build macro MULDIV_DIV_EN enables DIVU; without it md_op 01 is reserved.
`timescale 1ns/1ps
package ex_muldiv_ctrl_pkg;

  localparam int MD_WIDTH_DEF = 16;

  localparam logic [1:0] MD_MULU = 2'b00;
  localparam logic [1:0] MD_DIVU = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic md_op_legal(input logic [1:0] op);
`ifdef MULDIV_DIV_EN
    return (op == MD_MULU) || (op == MD_DIVU);
`else
    return (op == MD_MULU);
`endif
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_muldiv_iter.sv
// Radix-2 iterative datapath: shift-add multiply and (with MULDIV_DIV_EN) restoring divide.
// o_hi_nxt/o_lo_nxt show the accumulator/shift register after the current step.
`timescale 1ns/1ps
module muldiv_iter
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_b;

  // Multiply: add multiplicand when the shifted-out multiplier bit is set, then shift right.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_mul;
  logic [WIDTH-1:0] w_sh_mul;

  assign w_sum     = {1'b0, r_acc} + {1'b0, (r_sh[0] ? r_b : '0)};
  assign w_acc_mul = w_sum[WIDTH:1];
  assign w_sh_mul  = {w_sum[0], r_sh[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_div;
  logic [WIDTH-1:0] w_sh_div;

  // Divide: shift next dividend bit into the remainder, subtract divisor if it fits.
  assign w_rem_sh  = {r_acc, r_sh[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_diff    = WIDTH'(w_rem_sh - {1'b0, r_b});
  assign w_acc_div = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
  assign w_sh_div  = {r_sh[WIDTH-2:0], w_ge};

  assign o_hi_nxt = r_div ? w_acc_div : w_acc_mul;
  assign o_lo_nxt = r_div ? w_sh_div  : w_sh_mul;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= 1'b0;
    end else if (i_load) begin
      r_div <= i_div;
    end
  end
`else
  logic w_unused_div;
  assign w_unused_div = i_div;
  assign o_hi_nxt     = w_acc_mul;
  assign o_lo_nxt     = w_sh_mul;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_sh  <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_sh  <= i_opa;
      r_b   <= i_opb;
    end else if (i_step) begin
      r_acc <= o_hi_nxt;
      r_sh  <= o_lo_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide controller: FSM, step counter and pipeline stall handshake.
// Build macro MULDIV_DIV_EN enables DIVU (otherwise md_op 01 reports illegal).
`timescale 1ns/1ps
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             md_req,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_zero,
  output logic             illegal,
  output md_state_e        dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  md_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_res_valid;
  logic             r_illegal;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;

  logic             w_req;
  logic             w_legal;
  logic             w_dz;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;

  assign w_req   = ex_valid & md_req & ~flush;
  assign w_legal = md_op_legal(md_op);

`ifdef MULDIV_DIV_EN
  logic r_div_zero;
  assign w_dz     = (md_op == MD_DIVU) && (opb == '0);
  assign div_zero = r_div_zero;

  // Zero-divisor requests go straight to DONE, so the flag pulses with that entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= (r_state == ST_IDLE) && w_req && w_dz;
    end
  end
`else
  assign w_dz     = 1'b0;
  assign div_zero = 1'b0;
`endif

  assign w_load = (r_state == ST_IDLE) && w_req && w_legal && !w_dz;
  assign w_step = (r_state == ST_BUSY) && !flush;

  // Valid/ready: stall holds the EX instruction while the unit owns it; it drops
  // in DONE so the result retires with its instruction, and on flush.
  assign stall = ~rst & (((r_state == ST_IDLE) & w_req) | w_step);

  assign res_valid = r_res_valid;
  assign res_lo    = r_res_lo;
  assign res_hi    = r_res_hi;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_div    (md_op == MD_DIVU),
    .i_opa    (opa),
    .i_opb    (opb),
    .o_lo_nxt (w_lo_nxt),
    .o_hi_nxt (w_hi_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_res_lo    <= '0;
      r_res_hi    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_res_valid <= 1'b0;
          r_illegal   <= 1'b0;
          if (w_req) begin
            if (!w_legal) begin
              r_state     <= ST_DONE;
              r_res_valid <= 1'b1;
              r_illegal   <= 1'b1;
              r_res_lo    <= '0;
              r_res_hi    <= '0;
            end else if (w_dz) begin
              r_state     <= ST_DONE;
              r_res_valid <= 1'b1;
              r_res_lo    <= '1;
              r_res_hi    <= opa;
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_STEP) begin
            r_state     <= ST_DONE;
            r_cnt       <= '0;
            r_res_valid <= 1'b1;
            r_res_lo    <= w_lo_nxt;
            r_res_hi    <= w_hi_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // md_req here belongs to the retiring instruction and is ignored.
          r_state     <= ST_IDLE;
          r_res_valid <= 1'b0;
          r_illegal   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
